// File: rtl/periph_bus_timer_pkg.sv
// Shared definitions for the memory-mapped timer/LED/switch/7-seg peripheral.
// The register window has 6 words by default. With PERIPH_SYSTICK_EN defined
// it has 7 words, adding the SYSTICK counter.
package periph_bus_timer_pkg;

    // Default base address of the register window
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    // Byte offsets of each register inside the window
    localparam logic [4:0] OFS_TH      = 5'h00;
    localparam logic [4:0] OFS_TL      = 5'h04;
    localparam logic [4:0] OFS_TCON    = 5'h08;
    localparam logic [4:0] OFS_LED     = 5'h0C;
    localparam logic [4:0] OFS_SWITCH  = 5'h10;
    localparam logic [4:0] OFS_DIGI    = 5'h14;
    localparam logic [4:0] OFS_SYSTICK = 5'h18;

    // TCON control/status bit positions and width
    localparam int TCON_RUN = 0;
    localparam int TCON_IEN = 1;
    localparam int TCON_IST = 2;
    localparam int TCON_W   = 3;

    // Highest word index that belongs to the window
`ifdef PERIPH_SYSTICK_EN
    localparam logic [2:0] LAST_WORD = 3'd6;
`else
    localparam logic [2:0] LAST_WORD = 3'd5;
`endif

    // True when a word index inside the 32-byte block maps to a register
    function automatic logic wordMapped(input logic [2:0] wordIdx);
        return wordIdx <= LAST_WORD;
    endfunction

endpackage

// File: rtl/periph_bus_timer_if.sv
// Data-memory port between the core's MEM stage and the peripheral block.
// The master side drives the address, strobes and store data. The slave side
// returns combinational read data and the window hit flag.
interface periph_bus_timer_if;
    logic [31:0] iAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iWriteData;
    logic [31:0] oReadData;
    logic        oHit;

    modport master (
        output iAddr,
        output iMemRead,
        output iMemWrite,
        output iWriteData,
        input  oReadData,
        input  oHit
    );

    modport slave (
        input  iAddr,
        input  iMemRead,
        input  iMemWrite,
        input  iWriteData,
        output oReadData,
        output oHit
    );
endinterface

// File: rtl/periph_bus_timer_timer.sv
// Reloadable 32-bit timer: TH reload value, TL counter and TCON control/status.
// oIRQ comes straight from the TCON flop, so it adds no latency.
module periph_timer
    import periph_bus_timer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              thWe,
    input  logic              tlWe,
    input  logic              tconWe,
    input  logic [31:0]       wrData,
    output logic [31:0]       th,
    output logic [31:0]       tl,
    output logic [TCON_W-1:0] tcon,
    output logic              irq
);

    logic overflow;

    assign overflow = tcon[TCON_RUN] && (tl == 32'hFFFF_FFFF);
    assign irq      = tcon[TCON_IST] & tcon[TCON_IEN];

    // Reload register. The reload in an overflow cycle still sees the old TH.
    always_ff @(posedge clk) begin
        if (reset)
            th <= '0;
        else if (thWe)
            th <= wrData;
    end

    // Counter. A CPU write wins over both reload and increment.
    always_ff @(posedge clk) begin
        if (reset)
            tl <= '0;
        else if (tlWe)
            tl <= wrData;
        else if (overflow)
            tl <= th;
        else if (tcon[TCON_RUN])
            tl <= tl + 32'd1;
    end

    // Control/status. A CPU write wins over the sticky overflow status set.
    always_ff @(posedge clk) begin
        if (reset)
            tcon <= '0;
        else if (tconWe)
            tcon <= wrData[TCON_W-1:0];
        else if (overflow && tcon[TCON_IEN])
            tcon[TCON_IST] <= 1'b1;
    end

endmodule

// File: rtl/periph_bus_timer.sv
// Memory-mapped peripheral on the core's data-memory port. It holds a timer
// with an interrupt, LED, switch and 7-segment registers. Reads are
// combinational; writes commit at the clock edge.
// Optional feature macro: PERIPH_SYSTICK_EN adds a free-running read-only
// SYSTICK cycle counter at offset 0x18.
module periph_bus_timer
    import periph_bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    periph_bus_timer_if.slave    bus,
    output logic                 oIRQ,
    output logic [LED_W-1:0]     oLED,
    input  logic [SW_W-1:0]      iSwitch,
    output logic [11:0]          oDigi
);

    logic [4:0]        regOfs;
    logic              windowMatch;
    logic              hit;
    logic              wrEn;
    logic              unusedAddrBits;

    logic [31:0]       th;
    logic [31:0]       tl;
    logic [TCON_W-1:0] tcon;

    logic [LED_W-1:0]  ledReg;
    logic [11:0]       digiReg;
    logic [SW_W-1:0]   swMeta;
    logic [SW_W-1:0]   swSync;

    logic [31:0]       rdData;

    // Byte lanes are ignored, so registers are selected by word.
    assign regOfs         = {bus.iAddr[4:2], 2'b00};
    assign unusedAddrBits = ^bus.iAddr[1:0];
    assign windowMatch    = (bus.iAddr[31:5] == BASE_ADDR[31:5]);
    assign hit            = windowMatch && wordMapped(bus.iAddr[4:2]);
    assign wrEn           = bus.iMemWrite && hit;

    assign bus.oHit      = hit;
    assign bus.oReadData = rdData;
    assign oLED          = ledReg;
    assign oDigi         = digiReg;

    periph_timer uTimer (
        .clk    (clk),
        .reset  (reset),
        .thWe   (wrEn && (regOfs == OFS_TH)),
        .tlWe   (wrEn && (regOfs == OFS_TL)),
        .tconWe (wrEn && (regOfs == OFS_TCON)),
        .wrData (bus.iWriteData),
        .th     (th),
        .tl     (tl),
        .tcon   (tcon),
        .irq    (oIRQ)
    );

    // LED and 7-segment output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ledReg  <= '0;
            digiReg <= '0;
        end else begin
            if (wrEn && (regOfs == OFS_LED))
                ledReg <= bus.iWriteData[LED_W-1:0];
            if (wrEn && (regOfs == OFS_DIGI))
                digiReg <= bus.iWriteData[11:0];
        end
    end

    // Two-flop synchroniser for the asynchronous switch pins
    always_ff @(posedge clk) begin
        if (reset) begin
            swMeta <= '0;
            swSync <= '0;
        end else begin
            swMeta <= iSwitch;
            swSync <= swMeta;
        end
    end

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] sysTick;

    // Free-running cycle counter; wraps naturally from all ones to zero
    always_ff @(posedge clk) begin
        if (reset)
            sysTick <= '0;
        else
            sysTick <= sysTick + 32'd1;
    end
`endif

    // Combinational read mux; zero when not reading a mapped register
    always_comb begin
        rdData = '0;
        if (bus.iMemRead && hit) begin
            case (regOfs)
                OFS_TH:      rdData = th;
                OFS_TL:      rdData = tl;
                OFS_TCON:    rdData = 32'(tcon);
                OFS_LED:     rdData = 32'(ledReg);
                OFS_SWITCH:  rdData = 32'(swSync);
                OFS_DIGI:    rdData = 32'(digiReg);
`ifdef PERIPH_SYSTICK_EN
                OFS_SYSTICK: rdData = sysTick;
`endif
                default:     rdData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_timer.sv
// Directed bench for periph_bus_timer. Each scenario task drives stimulus and
// checks results inline against hand-computed values.
// Honours PERIPH_SYSTICK_EN when it is defined for the build.
module tb_periph_bus_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH     = BASE + 32'h00;
    localparam logic [31:0] A_TL     = BASE + 32'h04;
    localparam logic [31:0] A_TCON   = BASE + 32'h08;
    localparam logic [31:0] A_LED    = BASE + 32'h0C;
    localparam logic [31:0] A_SWITCH = BASE + 32'h10;
    localparam logic [31:0] A_DIGI   = BASE + 32'h14;
    localparam logic [31:0] A_SYS    = BASE + 32'h18;

    logic        clk;
    logic        reset;
    logic        oIRQ;
    logic [7:0]  oLED;
    logic [7:0]  iSwitch;
    logic [11:0] oDigi;

    int testsRun    = 0;
    int testsFailed = 0;

    periph_bus_timer_if bus ();

    periph_bus_timer #(
        .BASE_ADDR (BASE),
        .LED_W     (8),
        .SW_W      (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .oIRQ    (oIRQ),
        .oLED    (oLED),
        .iSwitch (iSwitch),
        .oDigi   (oDigi)
    );

    // 20 ns clock; stimulus changes and sampling happen in the low phase
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Drive a write from the low phase; it commits at the next rising edge
    task automatic wrReg(input logic [31:0] addr, input logic [31:0] data);
        bus.iAddr      = addr;
        bus.iWriteData = data;
        bus.iMemWrite  = 1'b1;
        @(negedge clk);
        bus.iMemWrite  = 1'b0;
        bus.iWriteData = '0;
    endtask

    // Combinational read, 1 ns, without crossing a clock edge
    task automatic rdReg(input logic [31:0] addr, output logic [31:0] data, output logic hit);
        bus.iAddr    = addr;
        bus.iMemRead = 1'b1;
        #1;
        data = bus.oReadData;
        hit  = bus.oHit;
        bus.iMemRead = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        h;
        for (int i = 0; i < 6; i++) begin
            rdReg(BASE + 32'(4 * i), d, h);
            testsRun++;
            if (d !== 32'h0 || h !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL reset_read_%0d: got data=%h hit=%b, expected data=0 hit=1", i, d, h);
            end
            idle(1);
        end
        testsRun++;
        if (oIRQ !== 1'b0 || oLED !== 8'h00 || oDigi !== 12'h000) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got irq=%b led=%h digi=%h, expected 0 0 0", oIRQ, oLED, oDigi);
        end
        rdReg(32'h4000_0020, d, h);
        testsRun++;
        if (d !== 32'h0 || h !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outside: got data=%h hit=%b, expected data=0 hit=0", d, h);
        end
        idle(1);
    endtask

    task automatic test_timer_overflow();
        logic [31:0] d;
        logic        h;
        wrReg(A_TH, 32'hFFFF_FFF0);
        wrReg(A_TL, 32'hFFFF_FFFE);
        wrReg(A_TCON, 32'h3);
        // Run just started: TL still holds the written value
        rdReg(A_TL, d, h);
        testsRun++;
        if (d !== 32'hFFFF_FFFE) begin
            testsFailed++;
            $display("[TB] FAIL tl_after_start: got %h, expected fffffffe", d);
        end
        idle(1);
        rdReg(A_TL, d, h);
        testsRun++;
        if (d !== 32'hFFFF_FFFF || oIRQ !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL tl_pre_overflow: got tl=%h irq=%b, expected ffffffff 0", d, oIRQ);
        end
        idle(1);
        rdReg(A_TL, d, h);
        testsRun++;
        if (d !== 32'hFFFF_FFF0) begin
            testsFailed++;
            $display("[TB] FAIL tl_reload: got %h, expected fffffff0", d);
        end
        rdReg(A_TCON, d, h);
        testsRun++;
        if (d !== 32'h7 || oIRQ !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL tcon_after_overflow: got tcon=%h irq=%b, expected 7 1", d, oIRQ);
        end
    endtask

    task automatic test_tcon_write_priority();
        logic [31:0] d;
        logic        h;
        wrReg(A_TL, 32'hFFFF_FFFF);
        // This write lands in the overflow cycle
        wrReg(A_TCON, 32'h3);
        rdReg(A_TCON, d, h);
        testsRun++;
        if (d !== 32'h3 || oIRQ !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL tcon_write_wins: got tcon=%h irq=%b, expected 3 0", d, oIRQ);
        end
        rdReg(A_TL, d, h);
        testsRun++;
        if (d !== 32'hFFFF_FFF0) begin
            testsFailed++;
            $display("[TB] FAIL tl_reload_2: got %h, expected fffffff0", d);
        end
        wrReg(A_TL, 32'hFFFF_FFFF);
        idle(1);
        rdReg(A_TCON, d, h);
        testsRun++;
        if (d !== 32'h7 || oIRQ !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL irq_sets_again: got tcon=%h irq=%b, expected 7 1", d, oIRQ);
        end
        // TH write in the overflow cycle: reload must use the old TH
        wrReg(A_TL, 32'hFFFF_FFFF);
        wrReg(A_TH, 32'h1234_5678);
        rdReg(A_TL, d, h);
        testsRun++;
        if (d !== 32'hFFFF_FFF0) begin
            testsFailed++;
            $display("[TB] FAIL reload_old_th: got %h, expected fffffff0", d);
        end
        rdReg(A_TH, d, h);
        testsRun++;
        if (d !== 32'h1234_5678) begin
            testsFailed++;
            $display("[TB] FAIL th_written: got %h, expected 12345678", d);
        end
    endtask

    task automatic test_tl_write_and_leds();
        logic [31:0] d;
        logic        h;
        wrReg(A_TL, 32'hFFFF_FFFF);
        wrReg(A_TL, 32'h5);
        rdReg(A_TL, d, h);
        testsRun++;
        if (d !== 32'h5) begin
            testsFailed++;
            $display("[TB] FAIL tl_write_wins: got %h, expected 00000005", d);
        end
        wrReg(A_TCON, 32'h0);
        rdReg(A_TCON, d, h);
        testsRun++;
        if (d !== 32'h0 || oIRQ !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL tcon_clear: got tcon=%h irq=%b, expected 0 0", d, oIRQ);
        end
        wrReg(A_LED, 32'h1A5);
        rdReg(A_LED, d, h);
        testsRun++;
        if (oLED !== 8'hA5 || d !== 32'hA5) begin
            testsFailed++;
            $display("[TB] FAIL led_write: got oLED=%h read=%h, expected a5 000000a5", oLED, d);
        end
        wrReg(A_DIGI, 32'hABCD_E5A3);
        rdReg(A_DIGI, d, h);
        testsRun++;
        if (oDigi !== 12'h5A3 || d !== 32'h5A3) begin
            testsFailed++;
            $display("[TB] FAIL digi_write: got oDigi=%h read=%h, expected 5a3 000005a3", oDigi, d);
        end
    endtask

    task automatic test_read_write_same_cycle();
        logic [31:0] d;
        logic        h;
        bus.iAddr      = A_LED;
        bus.iWriteData = 32'h11;
        bus.iMemRead   = 1'b1;
        bus.iMemWrite  = 1'b1;
        #1;
        testsRun++;
        if (bus.oReadData !== 32'hA5) begin
            testsFailed++;
            $display("[TB] FAIL rw_old_value: got %h, expected 000000a5", bus.oReadData);
        end
        @(negedge clk);
        bus.iMemRead  = 1'b0;
        bus.iMemWrite = 1'b0;
        rdReg(A_LED, d, h);
        testsRun++;
        if (d !== 32'h11 || oLED !== 8'h11) begin
            testsFailed++;
            $display("[TB] FAIL rw_commit: got read=%h oLED=%h, expected 00000011 11", d, oLED);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic        h;
        rdReg(BASE + 32'h3, d, h);
        testsRun++;
        if (d !== 32'h1234_5678 || h !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL byte_lane_ignored: got data=%h hit=%b, expected 12345678 1", d, h);
        end
        rdReg(32'h5000_0000, d, h);
        testsRun++;
        if (d !== 32'h0 || h !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL other_base: got data=%h hit=%b, expected 0 0", d, h);
        end
        bus.iAddr    = A_LED;
        bus.iMemRead = 1'b0;
        #1;
        testsRun++;
        if (bus.oReadData !== 32'h0 || bus.oHit !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL no_read_strobe: got data=%h hit=%b, expected 0 1", bus.oReadData, bus.oHit);
        end
        idle(1);
        rdReg(BASE + 32'h1C, d, h);
        testsRun++;
        if (d !== 32'h0 || h !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL offset_1c: got data=%h hit=%b, expected 0 0", d, h);
        end
        rdReg(A_SYS, d, h);
        testsRun++;
`ifdef PERIPH_SYSTICK_EN
        if (h !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL systick_hit: got hit=%b, expected 1", h);
        end
`else
        if (d !== 32'h0 || h !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL offset_18: got data=%h hit=%b, expected 0 0", d, h);
        end
`endif
        idle(1);
    endtask

    task automatic test_switch();
        logic [31:0] d;
        logic        h;
        iSwitch = 8'h3C;
        rdReg(A_SWITCH, d, h);
        testsRun++;
        if (d !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL switch_edge0: got %h, expected 0", d);
        end
        idle(1);
        rdReg(A_SWITCH, d, h);
        testsRun++;
        if (d !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL switch_edge1: got %h, expected 0", d);
        end
        idle(1);
        rdReg(A_SWITCH, d, h);
        testsRun++;
        if (d !== 32'h3C) begin
            testsFailed++;
            $display("[TB] FAIL switch_edge2: got %h, expected 0000003c", d);
        end
        wrReg(A_SWITCH, 32'hFF);
        rdReg(A_SWITCH, d, h);
        testsRun++;
        if (d !== 32'h3C) begin
            testsFailed++;
            $display("[TB] FAIL switch_readonly: got %h, expected 0000003c", d);
        end
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] d;
        logic        h;
        wrReg(A_TCON, 32'h1);
        wrReg(A_TL, 32'd100);
        rdReg(A_TL, d, h);
        testsRun++;
        if (d !== 32'd100) begin
            testsFailed++;
            $display("[TB] FAIL tl_before_reset: got %h, expected 00000064", d);
        end
        // Reset together with a LED write: reset must win
        reset          = 1'b1;
        bus.iAddr      = A_LED;
        bus.iWriteData = 32'hFF;
        bus.iMemWrite  = 1'b1;
        @(negedge clk);
        reset          = 1'b0;
        bus.iMemWrite  = 1'b0;
        rdReg(A_TL, d, h);
        testsRun++;
        if (d !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL tl_after_reset: got %h, expected 0", d);
        end
        rdReg(A_TCON, d, h);
        testsRun++;
        if (d !== 32'h0 || oIRQ !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL tcon_after_reset: got tcon=%h irq=%b, expected 0 0", d, oIRQ);
        end
        rdReg(A_SWITCH, d, h);
        testsRun++;
        if (d !== 32'h0 || oLED !== 8'h00 || oDigi !== 12'h000) begin
            testsFailed++;
            $display("[TB] FAIL regs_after_reset: got sw=%h led=%h digi=%h, expected 0 0 0", d, oLED, oDigi);
        end
`ifdef PERIPH_SYSTICK_EN
        rdReg(A_SYS, d, h);
        testsRun++;
        if (d !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL systick_reset: got %h, expected 0", d);
        end
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            rdReg(A_SYS, d, h);
            testsRun++;
            if (d !== 32'(i)) begin
                testsFailed++;
                $display("[TB] FAIL systick_count_%0d: got %h, expected %h", i, d, 32'(i));
            end
        end
`endif
        idle(1);
        rdReg(A_TL, d, h);
        testsRun++;
        if (d !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL tl_stays_stopped: got %h, expected 0", d);
        end
    endtask

    initial begin
        reset          = 1'b1;
        iSwitch        = '0;
        bus.iAddr      = '0;
        bus.iMemRead   = 1'b0;
        bus.iMemWrite  = 1'b0;
        bus.iWriteData = '0;
        idle(3);
        reset = 1'b0;

        test_reset();
        test_timer_overflow();
        test_tcon_write_priority();
        test_tl_write_and_leds();
        test_read_write_same_cycle();
        test_decode();
        test_switch();
        test_reset_mid_count();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
